// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch interface, fetch queue and fetch unit.
package if_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] pc_align(
    input logic [XLEN-1:0] a
  );
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response channel plus
// the head-of-queue view presented to the IF/ID register.
interface if_fetch_unit_if;
  import if_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output if_valid,
    output if_pc,
    output if_instr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  if_valid,
    input  if_pc,
    input  if_instr
  );

endinterface

// File: rtl/if_fetch_queue.sv
// In-order fetch queue of {pc, instr} entries.
// Clear wins over push/pop; pointers wrap mod DEPTH.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  fq_entry_t     push_data_i,
  input  logic          pop_i,
  output fq_entry_t     head_o,
  output logic [CW-1:0] count_o
);

  fq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic do_push;
  logic do_pop;
  logic full;

  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push_i && !clear_i;
  assign do_pop  = pop_i && !clear_i && (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // The credit scheme upstream must make this unreachable.
  no_overflow_a: assert property (
    @(posedge clk) disable iff (rst) do_push |-> !full
  );

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, imem credits, drop counter.
// Optional perf counters under `IF_PERF_CNT_EN.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  if_fetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_dropped
`endif
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic [XLEN-1:0] target;
  fq_entry_t       head;
  fq_entry_t       push_data;

  logic req, issue, rvalid, drop_hit, push, pop, valid;

  assign target = pc_align(redirect_pc);
  assign rvalid = bus.imem_rvalid;

  assign used  = {1'b0, count} + {1'b0, inflight_q};
  assign req   = !rst && !redirect
              && (used < (CW+1)'(FQ_DEPTH));
  assign issue = req && bus.imem_gnt;

  assign drop_hit = rvalid && (drop_q != '0);
  assign push     = rvalid && !drop_hit && !redirect;

  assign valid = !rst && (count != '0);
  assign pop   = valid && !stall && !redirect;

  assign push_data.pc    = resp_pc_q;
  assign push_data.instr = bus.imem_rdata;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CW'(issue) - CW'(rvalid);
    drop_d     = drop_q;
    if (redirect) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      // Every request still outstanding belongs to the old path.
      drop_d     = inflight_q - CW'(rvalid);
    end else begin
      if (issue)    fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push)     resp_pc_d  = resp_pc_q + PC_STEP;
      if (drop_hit) drop_d     = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  if_fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (redirect),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.if_valid  = valid;
  assign bus.if_pc     = valid ? head.pc : '0;
  assign bus.if_instr  = valid ? head.instr : INSTR_NOP;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_q, redirects_q, dropped_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q   <= '0;
      redirects_q <= '0;
      dropped_q   <= '0;
    end else begin
      fetched_q   <= fetched_q + 32'(push);
      redirects_q <= redirects_q + 32'(redirect);
      dropped_q   <= dropped_q
                   + 32'(rvalid && (drop_hit || redirect));
    end
  end

  assign perf_fetched   = fetched_q;
  assign perf_redirects = redirects_q;
  assign perf_dropped   = dropped_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a 1..3-cycle imem model.
// Perf counters are checked when IF_PERF_CNT_EN is defined.
module tb_if_fetch_unit;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int n_cmp = 0;
  int n_err = 0;
  int lat = 1;

  if_fetch_unit_if bus();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_redirects, perf_dropped;
`endif

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_redirects (perf_redirects),
    .perf_dropped   (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fw(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [64:0] hd(
    input logic v, input logic [31:0] pc
  );
    return v ? {1'b1, pc, fw(pc)} : 65'h0;
  endfunction

  logic        mv1, mv2, mv3;
  logic [31:0] md1, md2, md3;

  always @(posedge clk) begin
    if (rst) begin
      mv1 <= 1'b0;
      mv2 <= 1'b0;
      mv3 <= 1'b0;
    end else begin
      mv1 <= bus.imem_req && bus.imem_gnt;
      md1 <= fw(bus.imem_addr);
      mv2 <= mv1;
      md2 <= md1;
      mv3 <= mv2;
      md3 <= md2;
    end
  end

  assign bus.imem_rvalid = (lat == 1) ? mv1 : (lat == 2) ? mv2 : mv3;
  assign bus.imem_rdata  = (lat == 1) ? md1 : (lat == 2) ? md2 : md3;

  logic [64:0] obs;
  assign obs = {bus.if_valid, bus.if_pc, bus.if_instr};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    bus.imem_gnt = 1'b1;
    lat = l;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.imem_gnt = 1'b1;
    lat = 1;
    tick();
    tick();
    smp();
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rst_req: got %b want 0", bus.imem_req);
    end
    n_cmp++;
    if (obs !== hd(0, 0)) begin
      n_err++;
      $display("FAIL rst_head: got %h want %h", obs, hd(0, 0));
    end
  endtask

  task automatic test_stream;
    do_reset(1);
    smp();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL first_req: got %b/%h want 1/0",
               bus.imem_req, bus.imem_addr);
    end
    tick();
    smp();
    n_cmp++;
    if (obs !== hd(0, 0)) begin
      n_err++;
      $display("FAIL stream_c1: got %h want %h", obs, hd(0, 0));
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      smp();
      n_cmp++;
      if (obs !== hd(1, 32'(4 * k))) begin
        n_err++;
        $display("FAIL stream_%0d: got %h want %h",
                 k, obs, hd(1, 32'(4 * k)));
      end
    end
  endtask

  task automatic test_stall;
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      n_cmp++;
      if (obs !== hd(1, 32'd12)) begin
        n_err++;
        $display("FAIL stall_hold_%0d: got %h want %h",
                 k, obs, hd(1, 32'd12));
      end
      if (k == 2) begin
        n_cmp++;
        if (bus.imem_req !== 1'b0) begin
          n_err++;
          $display("FAIL stall_req_drop: got %b want 0", bus.imem_req);
        end
      end
      if (k < 2) tick();
    end
    tick();
    stall = 1'b0;
    smp();
    n_cmp++;
    if ({bus.imem_req, obs} !== {1'b0, hd(1, 32'd12)}) begin
      n_err++;
      $display("FAIL stall_release: got %b/%h want 0/%h",
               bus.imem_req, obs, hd(1, 32'd12));
    end
    tick();
    smp();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'd28}) begin
      n_err++;
      $display("FAIL stall_resume_req: got %b/%h want 1/1c",
               bus.imem_req, bus.imem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        tick();
        smp();
      end
      n_cmp++;
      if (obs !== hd(1, 32'(16 + 4 * k))) begin
        n_err++;
        $display("FAIL stall_resume_%0d: got %h want %h",
                 k, obs, hd(1, 32'(16 + 4 * k)));
      end
    end
  endtask

  task automatic test_redirect_drop;
    do_reset(3);
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    smp();
    n_cmp++;
    if ({bus.imem_req, obs} !== {1'b0, hd(0, 0)}) begin
      n_err++;
      $display("FAIL redir_cycle: got %b/%h want 0/0",
               bus.imem_req, obs);
    end
    tick();
    redirect = 1'b0;
    smp();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h100}) begin
      n_err++;
      $display("FAIL redir_req: got %b/%h want 1/100",
               bus.imem_req, bus.imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      smp();
      n_cmp++;
      if (obs !== hd(0, 0)) begin
        n_err++;
        $display("FAIL redir_drop_%0d: got %h want 0", k, obs);
      end
    end
    tick();
    smp();
    n_cmp++;
    if (obs !== hd(1, 32'h100)) begin
      n_err++;
      $display("FAIL redir_first: got %h want %h",
               obs, hd(1, 32'h100));
    end
`ifdef IF_PERF_CNT_EN
    n_cmp++;
    if ({perf_fetched, perf_redirects, perf_dropped} !==
        {32'd1, 32'd1, 32'd2}) begin
      n_err++;
      $display("FAIL redir_perf: got %0d/%0d/%0d want 1/1/2",
               perf_fetched, perf_redirects, perf_dropped);
    end
`endif
    tick();
    smp();
    n_cmp++;
    if (obs !== hd(1, 32'h104)) begin
      n_err++;
      $display("FAIL redir_second: got %h want %h",
               obs, hd(1, 32'h104));
    end
  endtask

  task automatic test_gnt_low;
    do_reset(1);
    tick();
    tick();
    tick();
    bus.imem_gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      smp();
      n_cmp++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'd12}) begin
        n_err++;
        $display("FAIL gnt_hold_%0d: got %b/%h want 1/c",
                 k, bus.imem_req, bus.imem_addr);
      end
      n_cmp++;
      if (obs !== hd(k < 2, 32'(4 + 4 * k))) begin
        n_err++;
        $display("FAIL gnt_drain_%0d: got %h want %h",
                 k, obs, hd(k < 2, 32'(4 + 4 * k)));
      end
      tick();
    end
    bus.imem_gnt = 1'b1;
    smp();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr, bus.if_valid} !==
        {1'b1, 32'd12, 1'b0}) begin
      n_err++;
      $display("FAIL gnt_resume: got %b/%h/%b want 1/c/0",
               bus.imem_req, bus.imem_addr, bus.if_valid);
    end
    tick();
    tick();
    smp();
    n_cmp++;
    if (obs !== hd(1, 32'd12)) begin
      n_err++;
      $display("FAIL gnt_first: got %h want %h", obs, hd(1, 32'd12));
    end
    tick();
    smp();
    n_cmp++;
    if (obs !== hd(1, 32'd16)) begin
      n_err++;
      $display("FAIL gnt_second: got %h want %h", obs, hd(1, 32'd16));
    end
  endtask

  task automatic test_redirect_coincident;
    do_reset(2);
    tick();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_2002;
    smp();
    n_cmp++;
    if ({bus.imem_req, obs} !== {1'b0, hd(1, 0)}) begin
      n_err++;
      $display("FAIL coin_cycle: got %b/%h want 0/%h",
               bus.imem_req, obs, hd(1, 0));
    end
    tick();
    redirect = 1'b0;
    smp();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr, obs} !==
        {1'b1, 32'h2000, hd(0, 0)}) begin
      n_err++;
      $display("FAIL coin_req0: got %b/%h/%h want 1/2000/0",
               bus.imem_req, bus.imem_addr, obs);
    end
    tick();
    smp();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr, obs} !==
        {1'b1, 32'h2004, hd(0, 0)}) begin
      n_err++;
      $display("FAIL coin_req1: got %b/%h/%h want 1/2004/0",
               bus.imem_req, bus.imem_addr, obs);
    end
    tick();
    smp();
    n_cmp++;
    if (obs !== hd(0, 0)) begin
      n_err++;
      $display("FAIL coin_empty: got %h want 0", obs);
    end
    tick();
    smp();
    n_cmp++;
    if (obs !== hd(1, 32'h2000)) begin
      n_err++;
      $display("FAIL coin_first: got %h want %h",
               obs, hd(1, 32'h2000));
    end
`ifdef IF_PERF_CNT_EN
    n_cmp++;
    if ({perf_fetched, perf_redirects, perf_dropped} !==
        {32'd2, 32'd1, 32'd2}) begin
      n_err++;
      $display("FAIL coin_perf: got %0d/%0d/%0d want 2/1/2",
               perf_fetched, perf_redirects, perf_dropped);
    end
`endif
    tick();
    smp();
    n_cmp++;
    if (obs !== hd(1, 32'h2004)) begin
      n_err++;
      $display("FAIL coin_second: got %h want %h",
               obs, hd(1, 32'h2004));
    end
  endtask

  task automatic test_wrap;
    do_reset(1);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    smp();
    n_cmp++;
    if (bus.imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_redir_req: got %b want 0", bus.imem_req);
    end
    tick();
    redirect = 1'b0;
    smp();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_err++;
      $display("FAIL wrap_req_top: got %b/%h want 1/fffffffc",
               bus.imem_req, bus.imem_addr);
    end
    tick();
    smp();
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL wrap_req_zero: got %b/%h want 1/0",
               bus.imem_req, bus.imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      smp();
      n_cmp++;
      if (obs !== hd(1, 32'hFFFF_FFFC + 32'(4 * k))) begin
        n_err++;
        $display("FAIL wrap_head_%0d: got %h want %h",
                 k, obs, hd(1, 32'hFFFF_FFFC + 32'(4 * k)));
      end
    end
`ifdef IF_PERF_CNT_EN
    n_cmp++;
    if ({perf_fetched, perf_redirects, perf_dropped} !==
        {32'd3, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL wrap_perf: got %0d/%0d/%0d want 3/1/0",
               perf_fetched, perf_redirects, perf_dropped);
    end
`endif
  endtask

  initial begin
    bus.imem_gnt = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_gnt_low();
    test_redirect_coincident();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
